// File: rtl/apb_adv_timer_pkg.sv
// ---------------------------------------------------------------------------
// apb_adv_timer_pkg
//   Definitions shared by the APB advanced-timer subsystem.
//   Holds the input-capture FSM state encoding and the width of the
//   exported state bus, so software-visible state codes stay consistent
//   across every block that reports them.
// ---------------------------------------------------------------------------
package apb_adv_timer_pkg;

    // Width of the capture FSM state as exported on state_o.
    localparam int CAPT_STATE_W = 2;

    // Capture FSM states; the numeric codes are software visible.
    typedef enum logic [CAPT_STATE_W-1:0] {
        CAPT_IDLE      = 2'd0,
        CAPT_WAIT_EDGE = 2'd1,
        CAPT_MEAS_HIGH = 2'd2,
        CAPT_MEAS_LOW  = 2'd3
    } capt_state_e;

endpackage

// File: rtl/capture_edge_sync.sv
// ---------------------------------------------------------------------------
// capture_edge_sync
//   Brings one asynchronous input into the clk domain through a 2-flop
//   synchroniser, applies the polarity inversion and detects edges of the
//   resulting active level against a registered copy of that level.
//   Rising and falling edges take the same path, so they have identical
//   latency and measured widths carry no bias.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   sig        in   asynchronous input (already selected)
//   inv        in   1 = treat the low level of sig as active
//   act_edge   out  active level went 0->1 (combinational from flops)
//   inact_edge out  active level went 1->0 (combinational from flops)
// ---------------------------------------------------------------------------
module capture_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    input  logic inv,
    output logic act_edge,
    output logic inact_edge
);

    logic [1:0] sync_q;
    logic       lvl;
    logic       lvl_q;

    assign lvl = sync_q[1] ^ inv;

    // NOTE: clocked state is always written with non-blocking assignments so
    // every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            lvl_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], sig};
            lvl_q  <= lvl;
        end
    end

    // The two edges are mutually exclusive by construction.
    assign act_edge   =  lvl & ~lvl_q;
    assign inact_edge = ~lvl &  lvl_q;

endmodule

// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//   Input-capture companion to the PWM generator. Measures the period and
//   the active (post-inversion high) time of one selected external signal in
//   prescaled clock ticks and publishes each completed measurement with a
//   one-cycle valid pulse. Measurements run back to back: the active edge
//   that closes one period opens the next.
//
// Parameters
//   NUM_BITS  width of the measurement counters and results
//   N_EXTSIG  number of selectable external signals
//
// Ports
//   clk_i        in   clock
//   rst_i        in   asynchronous active-high reset
//   cfg_en_i     in   level enable, 0 forces IDLE
//   cfg_clr_i    in   pulse: clear results and overflow, re-arm capture
//   cfg_sel_i    in   input select, values >= N_EXTSIG pick signal_i[0]
//   cfg_inv_i    in   0 = rising edge starts a period, 1 = falling edge
//   cfg_presc_i  in   one tick every cfg_presc_i+1 clocks
//   signal_i     in   asynchronous external signals
//   period_o     out  last period in ticks
//   high_o       out  last active time in ticks
//   valid_o      out  one-cycle pulse when period_o/high_o update
//   overflow_o   out  sticky: a measurement exceeded 2^NUM_BITS-1 ticks
//   state_o      out  current FSM state
// ---------------------------------------------------------------------------
module pwm_capture
    import apb_adv_timer_pkg::*;
#(
    parameter int NUM_BITS = 16,
    parameter int N_EXTSIG = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cfg_en_i,
    input  logic                    cfg_clr_i,
    input  logic [7:0]              cfg_sel_i,
    input  logic                    cfg_inv_i,
    input  logic [7:0]              cfg_presc_i,
    input  logic [N_EXTSIG-1:0]     signal_i,
    output logic [NUM_BITS-1:0]     period_o,
    output logic [NUM_BITS-1:0]     high_o,
    output logic                    valid_o,
    output logic                    overflow_o,
    output logic [CAPT_STATE_W-1:0] state_o
);

    capt_state_e         state_q, state_d;

    // Configuration captured when capture is armed.
    logic [7:0]          sel_q;
    logic                inv_q;
    logic [7:0]          presc_q;

    logic [7:0]          presc_cnt_q;
    logic [NUM_BITS-1:0] cnt_q;
    logic [NUM_BITS-1:0] high_q;

    logic                idle;
    logic                measuring;
    logic [7:0]          sel_eff;
    logic                inv_eff;
    logic                sig_sel;
    logic                act_edge;
    logic                inact_edge;
    logic                tick;
    logic [NUM_BITS-1:0] cap;
    logic                ovf;

    // FSM decisions
    logic                latch_cfg;
    logic                cnt_clr;
    logic                capture_high;
    logic                publish;
    logic                set_ovf;
    logic                clr_res;

    assign idle      = (state_q == CAPT_IDLE);
    assign measuring = (state_q == CAPT_MEAS_HIGH) || (state_q == CAPT_MEAS_LOW);

    // While idle the live configuration feeds the input path, so the
    // synchroniser has already settled on the new source/polarity by the time
    // capture is armed and arming never produces a spurious edge. Once armed
    // the latched copy is used and later changes are ignored.
    assign sel_eff = idle ? cfg_sel_i : sel_q;
    assign inv_eff = idle ? cfg_inv_i : inv_q;

    // Out-of-range selects fall back to signal_i[0].
    // NOTE: every signal assigned in an always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sig_sel = signal_i[0];
        for (int i = 0; i < N_EXTSIG; i++) begin
            if (sel_eff == 8'(i)) begin
                sig_sel = signal_i[i];
            end
        end
    end

    capture_edge_sync u_edge_sync (
        .clk        (clk_i),
        .rst        (rst_i),
        .sig        (sig_sel),
        .inv        (inv_eff),
        .act_edge   (act_edge),
        .inact_edge (inact_edge)
    );

    // The captured value includes the current cycle's tick, so a width of
    // W clocks yields floor(W / (presc+1)) ticks.
    assign tick = (presc_cnt_q == presc_q);
    assign cap  = cnt_q + NUM_BITS'(tick);
    assign ovf  = measuring && tick && (&cnt_q);

    // ------------------------------------------------------------------
    // Next-state and control decode, in priority order:
    // disable > clear > overflow > edge events.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        latch_cfg    = 1'b0;
        cnt_clr      = 1'b0;
        capture_high = 1'b0;
        publish      = 1'b0;
        set_ovf      = 1'b0;
        clr_res      = 1'b0;

        if (!cfg_en_i) begin
            state_d = CAPT_IDLE;
            cnt_clr = 1'b1;
        end else if (cfg_clr_i) begin
            // Any edge in this cycle is discarded.
            state_d   = CAPT_WAIT_EDGE;
            clr_res   = 1'b1;
            cnt_clr   = 1'b1;
            latch_cfg = idle;
        end else if (ovf) begin
            state_d = CAPT_WAIT_EDGE;
            set_ovf = 1'b1;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                CAPT_IDLE: begin
                    state_d   = CAPT_WAIT_EDGE;
                    latch_cfg = 1'b1;
                    cnt_clr   = 1'b1;
                end
                CAPT_WAIT_EDGE: begin
                    // Counters stay at zero until the first active edge.
                    cnt_clr = 1'b1;
                    if (act_edge) begin
                        state_d = CAPT_MEAS_HIGH;
                    end
                end
                CAPT_MEAS_HIGH: begin
                    if (inact_edge) begin
                        capture_high = 1'b1;
                        state_d      = CAPT_MEAS_LOW;
                    end
                end
                CAPT_MEAS_LOW: begin
                    // Closing edge of this period is the opening edge of the next.
                    if (act_edge) begin
                        publish = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = CAPT_MEAS_HIGH;
                    end
                end
                default: begin
                    state_d = CAPT_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= CAPT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q   <= '0;
            inv_q   <= 1'b0;
            presc_q <= '0;
        end else if (latch_cfg) begin
            sel_q   <= cfg_sel_i;
            inv_q   <= cfg_inv_i;
            presc_q <= cfg_presc_i;
        end
    end

    // Prescaler and tick counter; they only advance while measuring.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_cnt_q <= '0;
            cnt_q       <= '0;
        end else if (cnt_clr) begin
            presc_cnt_q <= '0;
            cnt_q       <= '0;
        end else if (measuring) begin
            if (tick) begin
                presc_cnt_q <= '0;
                cnt_q       <= cnt_q + NUM_BITS'(1);
            end else begin
                presc_cnt_q <= presc_cnt_q + 8'd1;
            end
        end
    end

    // Result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            high_q     <= '0;
            period_o   <= '0;
            high_o     <= '0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            valid_o <= publish;
            if (clr_res) begin
                high_q     <= '0;
                period_o   <= '0;
                high_o     <= '0;
                overflow_o <= 1'b0;
            end else begin
                if (capture_high) begin
                    high_q <= cap;
                end
                if (publish) begin
                    period_o <= cap;
                    high_o   <= high_q;
                end
                if (set_ovf) begin
                    overflow_o <= 1'b1;
                end
            end
        end
    end

    assign state_o = state_q;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Input-capture companion to the advanced timer's PWM generator: measures the period and high time of an external pulse train. One of `signal_i` is selected, synchronised and edge-detected. Period and high time are counted in prescaled clock ticks. One-cycle `valid_o` publishes each completed measurement. It sits beside the timer modules in the APB advanced-timer subsystem and shares their `signal_i` bus and register-driven configuration style.

## Interface
- `NUM_BITS`, 16: width of the measurement counters and outputs.
- `N_EXTSIG`, 32: number of selectable external signals.

- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `cfg_en_i`, in, 1: level enable; 0 forces IDLE.
- `cfg_clr_i`, in, 1: one-cycle pulse that clears results, clears the overflow flag and re-arms capture.
- `cfg_sel_i`, in, 8: input select. Values ≥ `N_EXTSIG` select `signal_i[0]`.
- `cfg_inv_i`, in, 1: polarity. 0 = the rising edge starts a period; 1 = the falling edge starts it (input inverted).
- `cfg_presc_i`, in, 8: one tick every `cfg_presc_i`+1 clocks.
- `signal_i`, in, `N_EXTSIG`: asynchronous external signals.
- `period_o`, out, `NUM_BITS`: last period, in ticks.
- `high_o`, out, `NUM_BITS`: last active (post-inversion high) time, in ticks.
- `valid_o`, out, 1: one-cycle pulse when `period_o` and `high_o` update.
- `overflow_o`, out, 1: sticky flag; a measurement exceeded 2^`NUM_BITS`−1 ticks.
- `state_o`, out, 2: current FSM state.

## Operation
- Input path:
  - Selected bit goes through a 2-flop synchroniser, then is XORed with `cfg_inv_i`, then goes to a registered edge detector.
  - The detector produces `act_edge` (0→1) and `inact_edge` (1→0); both can never occur in the same cycle.
- `cfg_sel_i`, `cfg_inv_i` and `cfg_presc_i` are latched on the IDLE→WAIT_EDGE transition. Changes while enabled are ignored until the next re-arm.
- Prescaler and counter:
  - `tick` = (`presc_cnt` == latched presc).
  - On `tick`: `presc_cnt` ← 0 and `cnt` ← `cnt`+1. Otherwise `presc_cnt` increments.
  - Both counters reset to 0 on `act_edge`.
  - Captured value = `cnt` + `tick`, i.e. it includes the current cycle.
  - Result for a given presc: period = floor(P/(presc+1)).
- FSM states: IDLE=0, WAIT_EDGE=1, MEAS_HIGH=2, MEAS_LOW=3.
  - IDLE: counters held at 0. When `cfg_en_i`=1 → WAIT_EDGE.
  - WAIT_EDGE: `inact_edge` is ignored. `act_edge` clears the counters → MEAS_HIGH.
  - MEAS_HIGH: `inact_edge` latches the captured value into an internal high register → MEAS_LOW.
  - MEAS_LOW: `act_edge` does all of the following → MEAS_HIGH (back-to-back measurement, no gap):
    - `period_o` ← captured value;
    - `high_o` ← high register;
    - pulse `valid_o`;
    - clear the counters.
- Overflow: in MEAS_HIGH or MEAS_LOW, a `tick` with `cnt` = all-ones does the following:
  - `overflow_o` ← 1;
  - → WAIT_EDGE;
  - no `valid_o`; outputs hold their previous values.
  - This covers 0 % / 100 % duty and a stopped input.
- Priority, highest first: `rst_i` > `cfg_en_i`=0 > `cfg_clr_i` > overflow > edge events.
- `cfg_en_i`=0: go to IDLE.
  - `period_o`, `high_o` and `overflow_o` hold.
  - `valid_o` = 0.
- `cfg_clr_i`:
  - `period_o`, `high_o` and `overflow_o` ← 0;
  - counters ← 0;
  - next state is WAIT_EDGE if enabled, else IDLE.
  - An edge in the same cycle is discarded.

## Timing
- Reset values: `period_o`=0, `high_o`=0, `valid_o`=0, `overflow_o`=0, `state_o`=0 (IDLE). All internal flops are 0.
- Input latency:
  - Edge detection fires in cycle N+2, where cycle N is the first `clk_i` edge that samples the new level.
  - Outputs and state change at the end of cycle N+2.
  - Latency is identical for both edges, so measured widths carry no bias.
- `valid_o` is high for exactly one cycle. `period_o`/`high_o` are stable from that cycle until the next `valid_o`, `cfg_clr_i` or reset.
- Minimum measurable high/low width: 1 clock. Narrower pulses may be lost in the synchroniser.
- Counting is width-exact: no wrap, saturation via overflow only.
- Reset mid-measurement: immediate return to IDLE. Partial counts are discarded.

## Structure
- Shared package `apb_adv_timer_pkg` holds:
  - the capture FSM state encoding (IDLE/WAIT_EDGE/MEAS_HIGH/MEAS_LOW);
  - the `state_o` width constant.
- One sub-module, `capture_edge_sync`:
  - 2-flop synchroniser + polarity XOR + registered edge detector;
  - outputs `act_edge`/`inact_edge`.
- Top level contains the input mux, prescaler, counter, FSM and result registers.

## Test plan
- Basic measurement:
  - Stimulus: presc=0, `signal_i[3]` square wave, high 30 / low 70 clocks, sel=3, inv=0.
  - Response: first `valid_o` after the second rising edge; `period_o`=100, `high_o`=30; a `valid_o` on every following period.
- Prescaler:
  - Stimulus: presc=3, high 40 / period 120 clocks.
  - Response: `period_o`=30, `high_o`=10.
- Inversion:
  - Stimulus: inv=1, same waveform as the basic test.
  - Response: `period_o`=100, `high_o`=70.
- Overflow:
  - Stimulus: `NUM_BITS`=8, input held high after the first rising edge.
  - Response: after 256 ticks `overflow_o`=1, state → WAIT_EDGE, no `valid_o`; `cfg_clr_i` clears the flag.
- Control:
  - `cfg_en_i` dropped mid-MEAS_LOW → IDLE, outputs held, no `valid_o`.
  - `cfg_clr_i` in the same cycle as `act_edge` → edge ignored, state WAIT_EDGE.
  - Async `rst_i` mid-measurement → all outputs 0 immediately.
- Select range:
  - Stimulus: sel=40 with `N_EXTSIG`=32.
  - Response: measures `signal_i[0]`.
